pixel_plot_sink: RTL and testbench

//  Receiving end of the line-drawer pixel stream: accepts (x, y, colour, last)

---
 rtl/pixel_plot_sink.sv | 161 ++++++++++++++++
 tb/tb_pixel_plot_sink.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: FIFO-buffered pixel plotter for the VGA framebuffer.
// Clips off-screen points, writes y*H_RES+x, and pulses done on the last pixel.
module pixel_plot_sink #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int COLOUR_W   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [8:0]          pix_x,
  input  logic [7:0]          pix_y,
  input  logic [COLOUR_W-1:0] pix_colour,
  input  logic                pix_last,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_ack,
  output logic                done,
  output logic [7:0]          clip_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 9 + 8 + COLOUR_W + 1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [9:0] X_LIM = 10'(H_RES);
  localparam logic [8:0] Y_LIM = 9'(V_RES);

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, DONE} state_t;

  logic [ENT_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                ready_en_q;
  logic                fifo_full, fifo_empty;
  logic                push, pop;

  state_t              state_q, state_d;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOUR_W-1:0] data_q, data_d;
  logic                we_q, we_d;
  logic [7:0]          clip_q, clip_d;
  logic                off_screen;
  logic [ADDR_W-1:0]   lin_addr;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  // Ready comes up one cycle after reset release and never looks at inputs.
  assign pix_ready  = ready_en_q & ~fifo_full;
  assign push       = pix_valid & pix_ready;

  assign off_screen = ({1'b0, x_q} >= X_LIM) || ({1'b0, y_q} >= Y_LIM);
  assign lin_addr   = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {pix_x, pix_y, pix_colour, pix_last};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    clip_d  = clip_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          {x_d, y_d, col_d, last_d} = fifo_q[rd_ptr_q];
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (off_screen) begin
          if (clip_q != 8'hFF) clip_d = clip_q + 8'd1;
          state_d = last_q ? DONE : IDLE;
        end else begin
          addr_d  = lin_addr;
          data_d  = col_q;
          we_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          we_d    = 1'b0;
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      clip_q     <= '0;
    end else begin
      ready_en_q <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      col_q      <= col_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      clip_q     <= clip_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_we     = we_q;
  assign done       = (state_q == DONE);
  assign clip_count = clip_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// tb_pixel_plot_sink: directed checks of the pixel plot sink.
// Streams queued pixels, logs framebuffer writes and done pulses.
module tb_pixel_plot_sink;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset;
  logic              pix_valid;
  logic              pix_ready;
  logic [8:0]        pix_x;
  logic [7:0]        pix_y;
  logic [2:0]        pix_colour;
  logic              pix_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;
  logic              mem_we;
  logic              mem_ack;
  logic              done;
  logic [7:0]        clip_count;

  pixel_plot_sink dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .pix_last(pix_last),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_ack(mem_ack),
    .done(done), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] qx[$];
  logic [7:0] qy[$];
  logic [2:0] qc[$];
  logic       ql[$];
  int wa[$];
  int wd[$];
  int wc[$];
  int done_cnt, first_done, first_push, snap_pushed;
  logic snap_ready, snap_we;

  int exp3_a [8] = '{961, 1291, 1621, 1951, 2281, 2611, 2941, 3271};
  int exp3_d [8] = '{1, 2, 3, 4, 5, 6, 7, 0};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    qx.delete(); qy.delete(); qc.delete(); ql.delete();
  endtask

  task automatic add(input int x, input int y, input int c, input bit l);
    qx.push_back(9'(x));
    qy.push_back(8'(y));
    qc.push_back(3'(c));
    ql.push_back(l);
  endtask

  // Drives the queued pixels; mem_ack is held low for the first 'stall' cycles.
  task automatic stream(input int stall, input int budget, input bit must_finish);
    int idx = 0;
    int i = 0;
    int post = 0;
    bit hold = 1'b0;
    bit fin = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [2:0] pdata = '0;
    logic rdy;
    wa.delete(); wd.delete(); wc.delete();
    done_cnt = 0; first_done = -1; first_push = -1;
    while (i < budget && !fin) begin
      @(negedge clk);
      mem_ack = (i >= stall);
      if (hold)
        chk("stall_stable", {11'd0, mem_we, mem_addr, mem_data},
            {11'd0, 1'b1, paddr, pdata});
      hold  = mem_we && !mem_ack;
      paddr = mem_addr;
      pdata = mem_data;
      if (mem_we && mem_ack) begin
        wa.push_back(int'(mem_addr));
        wd.push_back(int'(mem_data));
        wc.push_back(i);
      end
      if (done) begin
        if (done_cnt == 0) first_done = i;
        done_cnt++;
      end
      if (idx == qx.size() && done_cnt > 0) post++;
      rdy = pix_ready;
      if (i == stall - 1) begin
        snap_pushed = idx;
        snap_ready  = rdy;
        snap_we     = mem_we;
      end
      if (idx < qx.size()) begin
        pix_valid  = 1'b1;
        pix_x      = qx[idx];
        pix_y      = qy[idx];
        pix_colour = qc[idx];
        pix_last   = ql[idx];
      end else begin
        pix_valid = 1'b0;
      end
      @(posedge clk);
      if (pix_valid && rdy) begin
        if (idx == 0) first_push = i;
        idx++;
      end
      i++;
      fin = (idx == qx.size() && done_cnt > 0 && post >= 3);
    end
    #1 pix_valid = 1'b0;
    if (must_finish) chk("finish_in_budget", {31'd0, fin}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    pix_colour = '0; pix_last = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, pix_ready}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_addr", {15'd0, mem_addr}, 0);
    chk("rst_data", {29'd0, mem_data}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_clip", {24'd0, clip_count}, 0);
    reset = 1'b0;

    // single pixel, latency and address
    clear_q(); add(5, 2, 3, 1'b1);
    stream(0, 40, 1'b1);
    chk("t1_nwr", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("t1_addr", wa[0], 645);
      chk("t1_data", wd[0], 3);
      chk("t1_wr_lat", wc[0] - first_push, 3);
    end
    chk("t1_done_lat", first_done - first_push, 4);
    chk("t1_ndone", done_cnt, 1);
    chk("t1_clip", {24'd0, clip_count}, 0);

    // corner pixel then clipped last pixel
    clear_q(); add(319, 239, 5, 1'b0); add(320, 0, 1, 1'b1);
    stream(0, 40, 1'b1);
    chk("t2_nwr", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("t2_addr", wa[0], 76799);
      chk("t2_data", wd[0], 5);
    end
    chk("t2_clip", {24'd0, clip_count}, 1);
    chk("t2_ndone", done_cnt, 1);

    // backpressure with mem_ack held low
    clear_q();
    for (int k = 0; k < 8; k++) add(k * 10 + 1, k + 3, (k + 1) % 8, k == 7);
    stream(10, 200, 1'b1);
    chk("t3_pushed_at_stall", snap_pushed, 5);
    chk("t3_ready_at_stall", {31'd0, snap_ready}, 0);
    chk("t3_we_at_stall", {31'd0, snap_we}, 1);
    chk("t3_nwr", wa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < wa.size()) begin
        chk($sformatf("t3_addr%0d", k), wa[k], exp3_a[k]);
        chk($sformatf("t3_data%0d", k), wd[k], exp3_d[k]);
      end
    end
    chk("t3_ndone", done_cnt, 1);

    // continuous valid, zero-wait ack
    clear_q();
    for (int k = 0; k < 8; k++) add(100 + k, 200, 7 - k, k == 7);
    stream(0, 200, 1'b1);
    chk("t4_nwr", wa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < wa.size()) begin
        chk($sformatf("t4_addr%0d", k), wa[k], 64100 + k);
        chk($sformatf("t4_data%0d", k), wd[k], 7 - k);
        if (k > 0) chk($sformatf("t4_gap%0d", k), wc[k] - wc[k-1], 3);
      end
    end
    chk("t4_ndone", done_cnt, 1);

    // reset in the middle of a stalled write
    clear_q();
    for (int k = 0; k < 4; k++) add(k + 50, 60, 2, 1'b0);
    stream(1000, 6, 1'b0);
    @(negedge clk);
    chk("t5_we_before", {31'd0, mem_we}, 1);
    reset = 1'b1;
    #1;
    chk("t5_we_reset", {31'd0, mem_we}, 0);
    chk("t5_ready_reset", {31'd0, pix_ready}, 0);
    chk("t5_addr_reset", {15'd0, mem_addr}, 0);
    chk("t5_done_reset", {31'd0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_q();
    stream(0, 6, 1'b0);
    chk("t5_idle_nwr", wa.size(), 0);
    chk("t5_idle_ndone", done_cnt, 0);
    clear_q(); add(7, 1, 6, 1'b1);
    stream(0, 40, 1'b1);
    chk("t5_nwr", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("t5_addr", wa[0], 327);
      chk("t5_data", wd[0], 6);
    end
    chk("t5_ndone", done_cnt, 1);

    // clip counter saturation
    chk("t6_clip_start", {24'd0, clip_count}, 0);
    clear_q();
    for (int k = 0; k < 300; k++) add(320 + (k % 100), 250, k % 8, k == 299);
    stream(0, 1500, 1'b1);
    chk("t6_nwr", wa.size(), 0);
    chk("t6_clip", {24'd0, clip_count}, 255);
    chk("t6_ndone", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
